stereo_frame_sequencer: RTL and testbench
=========================================

Name: stereo_frame_sequencer

Overview:
Frame-level controller placed directly in front of the Stereovision core on the RGB input stream. It starts and stops frame processing under software control and locks onto the start-of-frame marker. It regenerates tuser and tlast from its own counters so the core always receives exactly WIDTH x HEIGHT pixels. Malformed input lines or frames are repaired by skipping excess beats or padding missing ones, and the repair is reported through sticky status flags.

Parameters:
WIDTH, 3840, pixels per line
HEIGHT, 2160, lines per frame
MAX_SAMPLES_PER_CLOCK, 4, pixels per beat; WIDTH must be an exact multiple
AXIS_TDATA_WIDTH, 96, stream data width (3 x DATA_WIDTH x MAX_SAMPLES_PER_CLOCK)
Localparam BEATS = WIDTH/MAX_SAMPLES_PER_CLOCK; column counter width $clog2(BEATS), row counter width $clog2(HEIGHT)

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
ctrl_run  in  1  level; continuous frame processing while high
ctrl_single  in  1  one-cycle pulse; process exactly one frame
ctrl_clear_err  in  1  one-cycle pulse; clears the sticky error flags
status_busy  out  1  high in any state other than IDLE
status_frame_done  out  1  one-cycle pulse after a frame completes
status_err_sof  out  1  sticky; tuser arrived mid-frame
status_err_eol  out  1  sticky; tlast was early or late
s_axis_tready/tdata/tuser/tlast/tvalid  in/out  1/AXIS_TDATA_WIDTH/1/1/1  upstream stream
m_axis_tvalid/tdata/tuser/tlast/tready  out/in  1/AXIS_TDATA_WIDTH/1/1/1  stream to the Stereovision core

Behaviour:
- States: IDLE, WAIT_SOF, PASS, SKIP, PAD. State, counters, flags and single_mode are registered.
- Datapath is zero-latency combinational muxing: no data buffering.
- Reset (sampled on the aclk edge): state=IDLE, col=0, row=0, single_mode=0, all status outputs 0.
- While areset is asserted: m_axis_tvalid=0, s_axis_tready=0.
- IDLE: s_tready=0, m_tvalid=0.
  - ctrl_single -> WAIT_SOF with single_mode=1; this takes priority over ctrl_run.
  - otherwise ctrl_run=1 -> WAIT_SOF with single_mode=0.
- WAIT_SOF: s_tready=1, m_tvalid=0; every beat is discarded.
  - The first beat with tvalid && tuser is not consumed here: s_tready=0 in that cycle, and the state moves to PASS on the next cycle with col=row=0.
- PASS:
  - m_tvalid=s_tvalid, s_tready=m_tready, m_tdata=s_tdata.
  - m_tuser = (col==0 && row==0); m_tlast = (col==BEATS-1).
  - A transfer is counted on the m_tvalid && m_tready handshake.
  - s_tuser=1 on a beat with (col,row)!=(0,0): the beat is not consumed (s_tready=0), m_tvalid=0, err_sof is set, and the state moves to PAD.
  - s_tlast=1 with col<BEATS-1: the beat is forwarded, err_eol is set, and the state moves to PAD.
  - s_tlast=0 with col==BEATS-1: the beat is forwarded with m_tlast=1, err_eol is set, and the state moves to SKIP. If this beat is the last beat of the frame, frame completion applies instead of SKIP.
- SKIP: s_tready=1, m_tvalid=0; beats are discarded.
  - A consumed beat with tlast returns the state to PASS; row has already advanced.
  - A beat with tuser is not consumed, err_sof is set, and the state moves to PAD.
- PAD: s_tready=0, m_tvalid=1, m_tdata=0; tuser and tlast are generated from the counters as in PASS.
  - The counters advance on each handshake until the frame is complete.
- Counters:
  - col wraps from BEATS-1 to 0 and increments row.
  - At (BEATS-1, HEIGHT-1) a handshake completes the frame: status_frame_done pulses on the next cycle, col=row=0.
  - Next state after completion is WAIT_SOF if ctrl_run && !single_mode, otherwise IDLE.
- ctrl_run falling mid-frame: the current frame completes normally, then the block goes to IDLE.
- Simultaneous ctrl_clear_err and a new error in the same cycle: the set wins.
- When m_tvalid=0, m_tdata, m_tuser and m_tlast are driven to 0.

Optional Feature:
- Macro: STEREO_SEQ_STATS_EN.
- With it defined, two extra outputs are added:
  - stat_frames [15:0]: completed frames, wrapping.
  - stat_repaired [15:0]: frames that entered PAD or SKIP at least once, counted at completion and saturating at 16'hFFFF.
  - Both clear on reset only.
- Without it, neither port nor its logic exists.

Decomposition:
- Package stereo_seq_pkg holds the state enum (seq_state_t), the BEATS computation function and the counter-width constants.
- One sub-module is natural: stereo_seq_geom_cnt, the col/row counter with an advance input and last_col/last_frame outputs.

Test Plan:
1. WIDTH=16, HEIGHT=4, SAMPLES=4 (4 beats/line), clean frame, ctrl_single pulse -> 16 beats forwarded with m_tuser on beat 0 and m_tlast on beats 3/7/11/15; frame_done pulses once; state returns to IDLE.
2. Early tlast on beat 1 of row 2 -> err_eol=1; 6 zero beats are padded (row 2 cols 2-3, row 3 cols 0-3); total downstream beats = 16.
3. Late tlast (row 1 has 6 input beats) -> m_tlast=1 on beat 7; the 2 extra input beats are discarded; rows 2-3 pass normally; err_eol=1.
4. tuser at row 2 col 0 -> err_sof=1; 8 zero beats are padded; the next frame starts from that held beat with ctrl_run=1.
5. m_tready toggles every other cycle plus random s_tvalid gaps -> no beat lost or duplicated; data matches a scoreboard.
6. areset asserted mid-PASS -> the next cycle has m_tvalid=0, status_busy=0, flags=0; ctrl_clear_err clears the flags; stat_frames wraps 16'hFFFF->0 (STATS_EN build).

Source files
------------

// File: rtl/stereo_seq_pkg.sv
// Shared definitions for the stereo frame sequencer: state encoding,
// line-geometry helpers and default counter widths.
package stereo_seq_pkg;

    // State encoding kept as plain vectors so older netlists and probes
    // that decode the raw state value stay compatible.
    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE     = 3'd0;
    localparam seq_state_t ST_WAIT_SOF = 3'd1;
    localparam seq_state_t ST_PASS     = 3'd2;
    localparam seq_state_t ST_SKIP     = 3'd3;
    localparam seq_state_t ST_PAD      = 3'd4;

    // Number of stream beats that make up one video line.
    function automatic int beats_f(input int width, input int samples);
        return width / samples;
    endfunction

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH   = 3840;
    localparam int DEF_HEIGHT  = 2160;
    localparam int DEF_SAMPLES = 4;
    localparam int DEF_COL_W   = cnt_w_f(beats_f(DEF_WIDTH, DEF_SAMPLES));
    localparam int DEF_ROW_W   = cnt_w_f(DEF_HEIGHT);

endpackage

// File: rtl/stereo_seq_geom_cnt.sv
// Column/row position counter for one frame. advance moves one beat
// forward; the last beat of the frame wraps both counters back to zero.
module stereo_seq_geom_cnt
    import stereo_seq_pkg::*;
#(
    parameter int BEATS  = 960,
    parameter int HEIGHT = 2160,
    parameter int COL_W  = cnt_w_f(BEATS),
    parameter int ROW_W  = cnt_w_f(HEIGHT)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clr,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_col,
    output logic             last_frame
);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             last_row_s;

    assign last_col   = (col_r == COL_W'(BEATS - 1));
    assign last_row_s = (row_r == ROW_W'(HEIGHT - 1));
    assign last_frame = last_col && last_row_s;
    assign col        = col_r;
    assign row        = row_r;

    // Step through the frame one beat at a time, wrapping at line and frame ends.
    always_ff @(posedge clk) begin
        if (areset || clr) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (advance) begin
            if (last_col) begin
                col_r <= {COL_W{1'b0}};
                row_r <= last_row_s ? {ROW_W{1'b0}} : (row_r + ROW_W'(1));
            end else begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/stereo_frame_sequencer.sv
// Frame sequencer in front of the Stereovision core. Locks onto start of
// frame, regenerates tuser/tlast from its own counters and repairs
// malformed lines by skipping or zero-padding beats.
// Optional build macro STEREO_SEQ_STATS_EN adds frame/repair statistics.
module stereo_frame_sequencer
    import stereo_seq_pkg::*;
#(
    parameter int WIDTH                 = 3840,
    parameter int HEIGHT                = 2160,
    parameter int MAX_SAMPLES_PER_CLOCK = 4,
    parameter int AXIS_TDATA_WIDTH      = 96
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        ctrl_run,
    input  logic                        ctrl_single,
    input  logic                        ctrl_clear_err,
    output logic                        status_busy,
    output logic                        status_frame_done,
    output logic                        status_err_sof,
    output logic                        status_err_eol,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tuser,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        m_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready
`ifdef STEREO_SEQ_STATS_EN
    ,
    output logic [15:0]                 stat_frames,
    output logic [15:0]                 stat_repaired
`endif
);

    localparam int BEATS = beats_f(WIDTH, MAX_SAMPLES_PER_CLOCK);
    localparam int COL_W = cnt_w_f(BEATS);
    localparam int ROW_W = cnt_w_f(HEIGHT);

    seq_state_t             state_r;
    seq_state_t             state_nxt_s;
    logic                   single_mode_r;
    logic                   single_nxt_s;
    logic                   err_sof_r;
    logic                   err_eol_r;
    logic                   frame_done_r;
    logic                   set_sof_s;
    logic                   set_eol_s;
    logic                   repair_s;
    logic                   complete_s;
    logic                   advance_s;
    logic                   clr_cnt_s;

    logic [COL_W-1:0]       col_s;
    logic [ROW_W-1:0]       row_s;
    logic                   last_col_s;
    logic                   last_frame_s;
    logic                   first_beat_s;

    logic                        s_tready_s;
    logic                        m_tvalid_s;
    logic [AXIS_TDATA_WIDTH-1:0] m_tdata_s;
    logic                        m_tuser_s;
    logic                        m_tlast_s;

    stereo_seq_geom_cnt #(
        .BEATS  (BEATS),
        .HEIGHT (HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_geom (
        .clk        (aclk),
        .areset     (areset),
        .clr        (clr_cnt_s),
        .advance    (advance_s),
        .col        (col_s),
        .row        (row_s),
        .last_col   (last_col_s),
        .last_frame (last_frame_s)
    );

    assign first_beat_s = (col_s == {COL_W{1'b0}}) && (row_s == {ROW_W{1'b0}});

    // Next-state, stream muxing and error detection for the current beat.
    always_comb begin
        state_nxt_s  = state_r;
        single_nxt_s = single_mode_r;
        set_sof_s    = 1'b0;
        set_eol_s    = 1'b0;
        repair_s     = 1'b0;
        complete_s   = 1'b0;
        advance_s    = 1'b0;
        clr_cnt_s    = 1'b0;
        s_tready_s   = 1'b0;
        m_tvalid_s   = 1'b0;
        m_tdata_s    = {AXIS_TDATA_WIDTH{1'b0}};
        m_tuser_s    = 1'b0;
        m_tlast_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (ctrl_single) begin
                    state_nxt_s  = ST_WAIT_SOF;
                    single_nxt_s = 1'b1;
                end else if (ctrl_run) begin
                    state_nxt_s  = ST_WAIT_SOF;
                    single_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end

            ST_WAIT_SOF: begin
                // The start-of-frame beat is held upstream and taken in PASS.
                if (s_axis_tvalid && s_axis_tuser) begin
                    s_tready_s  = 1'b0;
                    clr_cnt_s   = 1'b1;
                    state_nxt_s = ST_PASS;
                end else begin
                    s_tready_s  = 1'b1;
                end
            end

            ST_PASS: begin
                if (s_axis_tvalid && s_axis_tuser && !first_beat_s) begin
                    // A new frame started early: hold it and pad out the current one.
                    set_sof_s   = 1'b1;
                    repair_s    = 1'b1;
                    state_nxt_s = ST_PAD;
                end else begin
                    m_tvalid_s = s_axis_tvalid;
                    s_tready_s = m_axis_tready;
                    m_tdata_s  = s_axis_tdata;
                    m_tuser_s  = first_beat_s;
                    m_tlast_s  = last_col_s;
                    if (s_axis_tvalid && m_axis_tready) begin
                        advance_s = 1'b1;
                        if (last_frame_s) begin
                            complete_s = 1'b1;
                            set_eol_s  = !s_axis_tlast;
                        end else if (s_axis_tlast && !last_col_s) begin
                            set_eol_s   = 1'b1;
                            repair_s    = 1'b1;
                            state_nxt_s = ST_PAD;
                        end else if (!s_axis_tlast && last_col_s) begin
                            set_eol_s   = 1'b1;
                            repair_s    = 1'b1;
                            state_nxt_s = ST_SKIP;
                        end else begin
                            state_nxt_s = ST_PASS;
                        end
                    end else begin
                        state_nxt_s = ST_PASS;
                    end
                end
            end

            ST_SKIP: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    set_sof_s   = 1'b1;
                    repair_s    = 1'b1;
                    state_nxt_s = ST_PAD;
                end else begin
                    s_tready_s = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_nxt_s = ST_PASS;
                    end else begin
                        state_nxt_s = ST_SKIP;
                    end
                end
            end

            ST_PAD: begin
                m_tvalid_s = 1'b1;
                m_tuser_s  = first_beat_s;
                m_tlast_s  = last_col_s;
                if (m_axis_tready) begin
                    advance_s  = 1'b1;
                    complete_s = last_frame_s;
                end else begin
                    advance_s  = 1'b0;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (complete_s) begin
            state_nxt_s = (ctrl_run && !single_mode_r) ? ST_WAIT_SOF : ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Control state, sticky error flags and the frame-done pulse.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= ST_IDLE;
            single_mode_r <= 1'b0;
            err_sof_r     <= 1'b0;
            err_eol_r     <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            single_mode_r <= single_nxt_s;
            frame_done_r  <= complete_s;
            // A new error in the same cycle as a clear request keeps the flag set.
            err_sof_r     <= set_sof_s | (err_sof_r & ~ctrl_clear_err);
            err_eol_r     <= set_eol_s | (err_eol_r & ~ctrl_clear_err);
        end
    end

    assign status_busy       = (state_r != ST_IDLE);
    assign status_frame_done = frame_done_r;
    assign status_err_sof    = err_sof_r;
    assign status_err_eol    = err_eol_r;

    assign s_axis_tready = s_tready_s && !areset;
    assign m_axis_tvalid = m_tvalid_s && !areset;
    assign m_axis_tdata  = m_axis_tvalid ? m_tdata_s : {AXIS_TDATA_WIDTH{1'b0}};
    assign m_axis_tuser  = m_axis_tvalid ? m_tuser_s : 1'b0;
    assign m_axis_tlast  = m_axis_tvalid ? m_tlast_s : 1'b0;

`ifdef STEREO_SEQ_STATS_EN
    logic        repaired_r;
    logic [15:0] stat_frames_r;
    logic [15:0] stat_repaired_r;

    // Count completed frames and frames that needed any repair.
    always_ff @(posedge aclk) begin
        if (areset) begin
            repaired_r      <= 1'b0;
            stat_frames_r   <= 16'h0000;
            stat_repaired_r <= 16'h0000;
        end else if (complete_s) begin
            repaired_r    <= 1'b0;
            stat_frames_r <= stat_frames_r + 16'h0001;
            if ((repaired_r || repair_s) && (stat_repaired_r != 16'hFFFF)) begin
                stat_repaired_r <= stat_repaired_r + 16'h0001;
            end else begin
                stat_repaired_r <= stat_repaired_r;
            end
        end else begin
            repaired_r      <= repaired_r | repair_s;
            stat_frames_r   <= stat_frames_r;
            stat_repaired_r <= stat_repaired_r;
        end
    end

    assign stat_frames   = stat_frames_r;
    assign stat_repaired = stat_repaired_r;
`endif

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// Directed bench for stereo_frame_sequencer with a 16x4 frame of 4-pixel beats.
module tb_stereo_frame_sequencer;

    localparam int W   = 16;
    localparam int H   = 4;
    localparam int S   = 4;
    localparam int TDW = 96;

    logic           aclk = 1'b0;
    logic           areset;
    logic           ctrl_run, ctrl_single, ctrl_clear_err;
    logic           status_busy, status_frame_done, status_err_sof, status_err_eol;
    logic           s_axis_tready, s_axis_tuser, s_axis_tlast, s_axis_tvalid;
    logic [TDW-1:0] s_axis_tdata;
    logic           m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
    logic [TDW-1:0] m_axis_tdata;

    int          vectors     = 0;
    int          miscompares = 0;
    int          done_cnt    = 0;
    bit          tog_en      = 1'b0;
    logic [97:0] cap_q[$];
    logic [97:0] exp_q[$];

    always #5 aclk = ~aclk;

    stereo_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .MAX_SAMPLES_PER_CLOCK(S), .AXIS_TDATA_WIDTH(TDW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .ctrl_run(ctrl_run), .ctrl_single(ctrl_single), .ctrl_clear_err(ctrl_clear_err),
        .status_busy(status_busy), .status_frame_done(status_frame_done),
        .status_err_sof(status_err_sof), .status_err_eol(status_err_eol),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    // Record every downstream handshake and every frame-done pulse.
    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) cap_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (status_frame_done) done_cnt++;
    end

    // Backpressure pattern: downstream ready toggles every cycle when enabled.
    always begin
        @(posedge aclk);
        #1;
        if (tog_en) m_axis_tready = ~m_axis_tready;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] bd(input int f, input int r, input int c);
        return {32'(f + 1), 32'(r), 32'(c)};
    endfunction

    task automatic expect_beat(input logic [95:0] d, input bit u, input bit l);
        exp_q.push_back({u, l, d});
    endtask

    task automatic expect_rows(input int f, input int r0, input int r1);
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < 4; c++)
                expect_beat(bd(f, r, c), (r == 0) && (c == 0), c == 3);
    endtask

    task automatic expect_pad(input int from_idx);
        for (int i = from_idx; i < 16; i++) expect_beat(96'd0, 1'b0, (i % 4) == 3);
    endtask

    // Present one beat and hold it until accepted (entered and left at posedge+1).
    task automatic send_beat(input logic [95:0] d, input bit u, input bit l);
        int n;
        bit ok;
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge aclk);
            ok = s_axis_tready;
            n++;
        end
        if (!ok) chk("send_timeout", 128'(ok), 128'(1));
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    endtask

    task automatic send_rows(input int f, input int r0, input int r1, input int gap_max);
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < 4; c++) begin
                int g;
                g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                repeat (g) begin @(posedge aclk); #1; end
                send_beat(bd(f, r, c), (r == 0) && (c == 0), c == 3);
            end
    endtask

    task automatic pulse_single();
        ctrl_single = 1'b1;
        @(posedge aclk); #1;
        ctrl_single = 1'b0;
    endtask

    task automatic pulse_clear();
        ctrl_clear_err = 1'b1;
        @(posedge aclk); #1;
        ctrl_clear_err = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge aclk);
        while (status_busy && n < 1000) begin @(negedge aclk); n++; end
        chk({tag, "_idle"}, 128'(status_busy), 128'(0));
        repeat (2) @(negedge aclk);
        @(posedge aclk); #1;
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, 128'(cap_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), (i < cap_q.size()) ? 128'(cap_q[i]) : 128'(0), 128'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int d0;
        areset = 1'b1; ctrl_run = 1'b0; ctrl_single = 1'b0; ctrl_clear_err = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", 128'(status_busy), 128'(0));
        chk("rst_mvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_sready", 128'(s_axis_tready), 128'(0));
        chk("rst_flags", 128'({status_err_sof, status_err_eol, status_frame_done}), 128'(0));
        @(posedge aclk); #1;
        areset = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end

        // 1: clean single frame
        d0 = done_cnt;
        pulse_single();
        @(negedge aclk);
        chk("t1_busy", 128'(status_busy), 128'(1));
        chk("t1_wait_mvalid", 128'(m_axis_tvalid), 128'(0));
        @(posedge aclk); #1;
        send_rows(0, 0, 3, 0);
        expect_rows(0, 0, 3);
        wait_idle("t1");
        cmp_stream("t1");
        chk("t1_done", 128'(done_cnt - d0), 128'(1));
        chk("t1_flags", 128'({status_err_sof, status_err_eol}), 128'(0));

        // 2: early tlast at row 2 col 1 -> pad 6 beats
        d0 = done_cnt;
        pulse_single();
        send_rows(2, 0, 1, 0);
        send_beat(bd(2, 2, 0), 1'b0, 1'b0);
        send_beat(bd(2, 2, 1), 1'b0, 1'b1);
        expect_rows(2, 0, 1);
        expect_beat(bd(2, 2, 0), 1'b0, 1'b0);
        expect_beat(bd(2, 2, 1), 1'b0, 1'b0);
        expect_pad(10);
        wait_idle("t2");
        cmp_stream("t2");
        chk("t2_done", 128'(done_cnt - d0), 128'(1));
        chk("t2_err_eol", 128'(status_err_eol), 128'(1));
        chk("t2_err_sof", 128'(status_err_sof), 128'(0));
        pulse_clear();
        @(negedge aclk);
        chk("t2_clear", 128'({status_err_sof, status_err_eol}), 128'(0));
        @(posedge aclk); #1;

        // 3: late tlast, row 1 has 6 input beats
        pulse_single();
        send_rows(3, 0, 0, 0);
        for (int c = 0; c < 6; c++) send_beat(bd(3, 1, c), 1'b0, c == 5);
        send_rows(3, 2, 3, 0);
        expect_rows(3, 0, 3);
        wait_idle("t3");
        cmp_stream("t3");
        chk("t3_err_eol", 128'(status_err_eol), 128'(1));
        pulse_clear();
        @(negedge aclk);
        chk("t3_clear", 128'(status_err_eol), 128'(0));
        @(posedge aclk); #1;

        // 4: tuser at row 2 col 0 in run mode; held beat starts the next frame
        d0 = done_cnt;
        ctrl_run = 1'b1;
        send_rows(4, 0, 1, 0);
        send_beat(bd(5, 0, 0), 1'b1, 1'b0);
        ctrl_run = 1'b0;
        for (int i = 1; i < 16; i++) send_beat(bd(5, i / 4, i % 4), 1'b0, (i % 4) == 3);
        expect_rows(4, 0, 1);
        expect_pad(8);
        expect_rows(5, 0, 3);
        wait_idle("t4");
        cmp_stream("t4");
        chk("t4_done", 128'(done_cnt - d0), 128'(2));
        chk("t4_err_sof", 128'(status_err_sof), 128'(1));
        chk("t4_err_eol", 128'(status_err_eol), 128'(0));

        // 5: downstream ready toggling plus random source gaps
        tog_en = 1'b1;
        pulse_single();
        send_rows(6, 0, 3, 2);
        expect_rows(6, 0, 3);
        wait_idle("t5");
        tog_en = 1'b0;
        @(posedge aclk); #2;
        m_axis_tready = 1'b1;
        cmp_stream("t5");

        // 6: reset in the middle of PASS
        pulse_single();
        for (int i = 0; i < 5; i++) send_beat(bd(7, i / 4, i % 4), i == 0, (i % 4) == 3);
        @(negedge aclk);
        chk("t6_pre_err_sof", 128'(status_err_sof), 128'(1));
        @(posedge aclk); #1;
        s_axis_tdata = bd(7, 1, 1); s_axis_tvalid = 1'b1;
        areset = 1'b1;
        @(negedge aclk);
        chk("t6_rst_mvalid", 128'(m_axis_tvalid), 128'(0));
        chk("t6_rst_sready", 128'(s_axis_tready), 128'(0));
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t6_busy", 128'(status_busy), 128'(0));
        chk("t6_flags", 128'({status_err_sof, status_err_eol, status_frame_done}), 128'(0));
        @(posedge aclk); #1;
        areset = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        cap_q.delete();
        pulse_single();
        send_rows(8, 0, 3, 0);
        expect_rows(8, 0, 3);
        wait_idle("t6");
        cmp_stream("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
